// File: rtl/bus_transfer_sequencer_if.sv
// Command/bus interface of bus_transfer_sequencer.
// master: control unit side (issues commands, observes bus control)
// slave : sequencer side
interface bus_transfer_sequencer_if #(
  parameter int unsigned SEL_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_src;
  logic [SEL_W-1:0] cmd_dst;
  logic [SEL_W-1:0] bus_select;
  logic [23:0]      dst_load;
  logic             busy;
  logic             xfer_done;
  logic             xfer_err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, bus_select, dst_load, busy, xfer_done, xfer_err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, bus_select, dst_load, busy, xfer_done, xfer_err
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues {src, dst} register-transfer commands, drives the
// 24-source bus mux select and pulses one destination load enable per transfer.
// Optional performance counters (xfer_count, err_count) under `BUS_XFER_PERF_EN.
module bus_transfer_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEL_W      = 5
) (
  input  logic                      clk,
  input  logic                      clr,
  bus_transfer_sequencer_if.slave   bus
`ifdef BUS_XFER_PERF_EN
  ,
  output logic [15:0]               xfer_count,
  output logic [7:0]                err_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NUM_CODES = 24;
  localparam logic [SEL_W-1:0] CODE_LIMIT = SEL_W'(NUM_CODES);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ERR} state_t;

  logic [SEL_W-1:0] fifo_src [FIFO_DEPTH];
  logic [SEL_W-1:0] fifo_dst [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [SEL_W-1:0] head_src, head_dst;
  logic             head_ok;

  state_t                 state, state_next;
  logic [SEL_W-1:0]       bus_select, sel_next;
  logic [SEL_W-1:0]       cur_dst, dst_next;
  logic [NUM_CODES-1:0]   dst_load, load_next;
  logic                   xfer_done, done_next;
  logic                   xfer_err, err_next;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign push     = bus.cmd_valid && !full;
  assign head_src = fifo_src[rd_ptr];
  assign head_dst = fifo_dst[rd_ptr];
  assign head_ok  = (head_src < CODE_LIMIT) && (head_dst < CODE_LIMIT);

  // Command storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr] <= bus.cmd_src;
      fifo_dst[wr_ptr] <= bus.cmd_dst;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state and registered-output values; IDLE, LOAD and ERR share the same exits.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    sel_next   = bus_select;
    dst_next   = cur_dst;
    load_next  = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      DRIVE: begin
        state_next = LOAD;
        load_next  = NUM_CODES'(1) << cur_dst;
        done_next  = 1'b1;
      end
      default: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_ok) begin
            state_next = DRIVE;
            sel_next   = head_src;
            dst_next   = head_dst;
          end else begin
            state_next = ERR;
            err_next   = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      bus_select <= '0;
      cur_dst    <= '0;
      dst_load   <= '0;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;
    end else begin
      state      <= state_next;
      bus_select <= sel_next;
      cur_dst    <= dst_next;
      dst_load   <= load_next;
      xfer_done  <= done_next;
      xfer_err   <= err_next;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.busy       = (state != IDLE) || !empty;
  assign bus.bus_select = bus_select;
  assign bus.dst_load   = dst_load;
  assign bus.xfer_done  = xfer_done;
  assign bus.xfer_err   = xfer_err;

`ifdef BUS_XFER_PERF_EN
  // Saturating counts of completed LOAD cycles and ERR cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      if (state == LOAD && xfer_count != '1) xfer_count <= xfer_count + 16'd1;
      if (state == ERR  && err_count  != '1) err_count  <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: directed scenarios with constant
// expectations plus a randomized run against a cycle-timing reference model.
module tb_bus_transfer_sequencer;

  logic clk = 1'b0;
  logic clr;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  bus_transfer_sequencer_if #(.SEL_W(5)) bus ();

`ifdef BUS_XFER_PERF_EN
  logic [15:0] xfer_count;
  logic [7:0]  err_count;
`endif

  bus_transfer_sequencer #(.FIFO_DEPTH(4), .SEL_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef BUS_XFER_PERF_EN
    ,
    .xfer_count (xfer_count),
    .err_count  (err_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    clr = 1'b1;
    #2;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_vec++; if (bus.dst_load !== 24'h0 || bus.bus_select !== 5'd0) begin n_bad++; $display("FAIL reset_outs load=%h sel=%0d exp 0/0", bus.dst_load, bus.bus_select); end
    n_vec++; if (bus.xfer_done !== 1'b0 || bus.xfer_err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses done=%b err=%b exp 0/0", bus.xfer_done, bus.xfer_err); end
    // queue three commands, then hit clr while the first is in LOAD
    bus.cmd_valid = 1'b1; bus.cmd_src = 5'd1; bus.cmd_dst = 5'd2; tick();
    bus.cmd_src = 5'd3; bus.cmd_dst = 5'd4; tick();
    bus.cmd_src = 5'd5; bus.cmd_dst = 5'd6; tick();
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus.dst_load != 24'h0) seen = 1'b1;
      else tick();
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL reset_wait_load timeout got=0 exp=1"); end
    clr = 1'b1;
    #1;
    n_vec++; if (bus.dst_load !== 24'h0) begin n_bad++; $display("FAIL reset_mid_load got=%h exp=0", bus.dst_load); end
    n_vec++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_flags busy=%b ready=%b exp 0/1", bus.busy, bus.cmd_ready); end
    n_vec++; if (bus.xfer_done !== 1'b0) begin n_bad++; $display("FAIL reset_mid_done got=%b exp=0", bus.xfer_done); end
    tick();
    clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++; if (bus.dst_load !== 24'h0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_discard k=%0d load=%h busy=%b exp 0/0", k, bus.dst_load, bus.busy); end
    end
  endtask

  task automatic test_single();
    logic [4:0]  es;
    logic [23:0] el;
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_src = 5'd20; bus.cmd_dst = 5'd22;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      es = (k >= 2) ? 5'd20 : 5'd0;
      el = (k == 3) ? 24'h400000 : 24'h0;
      n_vec++; if (bus.bus_select !== es) begin n_bad++; $display("FAIL single_sel T+%0d got=%0d exp=%0d", k, bus.bus_select, es); end
      n_vec++; if (bus.dst_load !== el || bus.xfer_done !== (k == 3)) begin n_bad++; $display("FAIL single_load T+%0d got=%h/%b exp=%h/%b", k, bus.dst_load, bus.xfer_done, el, (k == 3)); end
      n_vec++; if (bus.busy !== (k <= 3)) begin n_bad++; $display("FAIL single_busy T+%0d got=%b exp=%b", k, bus.busy, (k <= 3)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  es [9];
    logic [23:0] el [9];
    es = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd3, 5'd3, 5'd16, 5'd16, 5'd16};
    el = '{24'h0, 24'h0, 24'h0, 24'h4, 24'h0, 24'h10, 24'h0, 24'h1, 24'h0};
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_src = 5'd1;  bus.cmd_dst = 5'd2; tick();
    bus.cmd_src = 5'd3;  bus.cmd_dst = 5'd4; tick();
    bus.cmd_src = 5'd16; bus.cmd_dst = 5'd0; tick();
    bus.cmd_valid = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      n_vec++; if (bus.bus_select !== es[k]) begin n_bad++; $display("FAIL b2b_sel T+%0d got=%0d exp=%0d", k, bus.bus_select, es[k]); end
      n_vec++; if (bus.dst_load !== el[k]) begin n_bad++; $display("FAIL b2b_load T+%0d got=%h exp=%h", k, bus.dst_load, el[k]); end
      tick();
    end
  endtask

  task automatic test_invalid();
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_src = 5'd25; bus.cmd_dst = 5'd3; tick();
    bus.cmd_src = 5'd0; bus.cmd_dst = 5'd1; tick();
    bus.cmd_valid = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      n_vec++; if (bus.xfer_err !== (k == 2)) begin n_bad++; $display("FAIL invalid_err T+%0d got=%b exp=%b", k, bus.xfer_err, (k == 2)); end
      n_vec++; if (bus.dst_load !== ((k == 4) ? 24'h2 : 24'h0) || bus.xfer_done !== (k == 4)) begin
        n_bad++; $display("FAIL invalid_load T+%0d got=%h/%b exp=%h/%b", k, bus.dst_load, bus.xfer_done, (k == 4) ? 24'h2 : 24'h0, (k == 4));
      end
      tick();
    end
  endtask

  task automatic test_full();
    int idx, nload, first_block;
    do_reset();
    idx = 0; nload = 0; first_block = -1;
    for (int k = 0; k < 60; k++) begin
      if (bus.dst_load != 24'h0) begin
        n_vec++; if (!$onehot(bus.dst_load) || bus.dst_load !== (24'h1 << nload) || bus.bus_select !== 5'(nload + 8)) begin
          n_bad++; $display("FAIL full_order n=%0d got=%h/%0d exp=%h/%0d", nload, bus.dst_load, bus.bus_select, 24'h1 << nload, nload + 8);
        end
        nload++;
      end
      if (idx < 8) begin
        bus.cmd_valid = 1'b1; bus.cmd_src = 5'(idx + 8); bus.cmd_dst = 5'(idx);
        if (bus.cmd_ready) idx++;
        else if (first_block < 0) first_block = k;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      tick();
    end
    n_vec++; if (first_block != 7) begin n_bad++; $display("FAIL full_ready_drop got=%0d exp=7", first_block); end
    n_vec++; if (nload != 8) begin n_bad++; $display("FAIL full_count got=%0d exp=8", nload); end
  endtask

  task automatic test_random();
    localparam int NCYC = 400;
    localparam int NTOT = 460;
    int          occ    [1024];
    bit          active [1024];
    bit          err_at [1024];
    bit          sel_set[1024];
    logic [4:0]  sel_val[1024];
    logic [23:0] load_at[1024];
    logic [4:0]  cur_sel, s, d;
    int          last_l, dcy;
    bit          v;
    for (int i = 0; i < 1024; i++) begin
      occ[i] = 0; active[i] = 1'b0; err_at[i] = 1'b0; sel_set[i] = 1'b0;
      sel_val[i] = '0; load_at[i] = '0;
    end
    cur_sel = '0;
    last_l  = -100;
    do_reset();
    for (int c = 0; c < NTOT; c++) begin
      if (sel_set[c]) cur_sel = sel_val[c];
      n_vec++; if (bus.dst_load !== load_at[c] || bus.xfer_done !== (load_at[c] != 0)) begin
        n_bad++; $display("FAIL rand_load c=%0d got=%h/%b exp=%h/%b", c, bus.dst_load, bus.xfer_done, load_at[c], (load_at[c] != 0));
      end
      n_vec++; if (bus.xfer_err !== err_at[c]) begin n_bad++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, bus.xfer_err, err_at[c]); end
      n_vec++; if (bus.bus_select !== cur_sel) begin n_bad++; $display("FAIL rand_sel c=%0d got=%0d exp=%0d", c, bus.bus_select, cur_sel); end
      n_vec++; if (bus.busy !== (occ[c] > 0 || active[c])) begin n_bad++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, (occ[c] > 0 || active[c])); end
      n_vec++; if (bus.cmd_ready !== (occ[c] < 4)) begin n_bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.cmd_ready, (occ[c] < 4)); end
      v = (c < NCYC) && ($urandom_range(0, 99) < 60);
      s = 5'($urandom_range(0, 27));
      d = 5'($urandom_range(0, 27));
      bus.cmd_valid = v; bus.cmd_src = s; bus.cmd_dst = d;
      if (v && occ[c] < 4) begin
        // accepted at end of cycle c; popped at end of cycle dcy
        dcy = (c + 1 > last_l) ? c + 1 : last_l;
        for (int k = c + 1; k <= dcy; k++) occ[k]++;
        if (s < 24 && d < 24) begin
          sel_set[dcy + 1] = 1'b1;
          sel_val[dcy + 1] = s;
          active[dcy + 1]  = 1'b1;
          active[dcy + 2]  = 1'b1;
          load_at[dcy + 2] = 24'h1 << d;
          last_l = dcy + 2;
        end else begin
          active[dcy + 1] = 1'b1;
          err_at[dcy + 1] = 1'b1;
          last_l = dcy + 1;
        end
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

`ifdef BUS_XFER_PERF_EN
  task automatic test_perf();
    logic [4:0] srcs [4];
    srcs = '{5'd1, 5'd24, 5'd2, 5'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_src = srcs[i]; bus.cmd_dst = 5'(i + 4);
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (15) tick();
    n_vec++; if (xfer_count !== 16'd3) begin n_bad++; $display("FAIL perf_xfer got=%0d exp=3", xfer_count); end
    n_vec++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL perf_err got=%0d exp=1", err_count); end
    clr = 1'b1;
    #1;
    n_vec++; if (xfer_count !== 16'd0 || err_count !== 8'd0) begin n_bad++; $display("FAIL perf_clr got=%0d/%0d exp=0/0", xfer_count, err_count); end
    tick();
    clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_full();
    test_random();
`ifdef BUS_XFER_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
